// File: rtl/radiant_trigger_scheduler_pkg.sv
// Shared types and widths for the RADIANT trigger scheduler.
// Holds the scheduler state encoding and the counter widths used by the top level.
package radiant_trig_pkg;

    localparam int unsigned TRIG_NUM_W = 16;
    localparam int unsigned PEND_W     = 4;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_HOLDOFF  = 2'd2
    } trig_state_t;

endpackage

// File: rtl/radiant_trigger_scheduler_if.sv
// Link between the scheduler FSM and its holdoff down-counter.
// The master side loads and steps the counter; the slave side reports expiry.
interface radiant_trigger_scheduler_if #(
    parameter int unsigned HOLD_W = 8
);
    logic              load;
    logic [HOLD_W-1:0] value;
    logic              clear;
    logic              dec;
    logic              expired;

    modport master (output load, value, clear, dec, input expired);
    modport slave  (input load, value, clear, dec, output expired);
endinterface

// File: rtl/radiant_trigger_scheduler_holdoff.sv
// Holdoff down-counter: loaded on an accepted trigger, stepped while in holdoff.
// expired is high once the count is at 1 or below.
module radiant_trig_holdoff #(
    parameter int unsigned HOLD_W = 8
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    radiant_trigger_scheduler_if.slave   hif
);

    logic [HOLD_W-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (hif.clear) begin
            r_count <= '0;
        end else if (hif.load) begin
            r_count <= hif.value;
        end else if (hif.dec && (r_count != '0)) begin
            r_count <= r_count - HOLD_W'(1);
        end
    end

    assign hif.expired = (r_count <= HOLD_W'(1));

endmodule

// File: rtl/radiant_trigger_scheduler.sv
// RADIANT trigger scheduler: gates enabled trigger requests, applies holdoff,
// and tracks outstanding events against the LAB4 readout.
module radiant_trigger_scheduler
    import radiant_trig_pkg::*;
#(
    parameter int unsigned NSRC   = 4,
    parameter int unsigned NBUF   = 4,
    parameter int unsigned HOLD_W = 8
) (
    input  logic                  sys_clk_i,
    input  logic                  rst_i,
    input  logic [NSRC-1:0]       src_i,
    input  logic [NSRC-1:0]       src_en_i,
    input  logic                  en_i,
    input  logic [HOLD_W-1:0]     holdoff_i,
    input  logic                  readout_running_i,
    input  logic                  readout_done_i,
    input  logic                  readout_full_i,
    output logic                  trig_o,
    output logic [NSRC-1:0]       trig_src_o,
    output logic [TRIG_NUM_W-1:0] trig_num_o,
    output logic [PEND_W-1:0]     pending_o,
    output logic                  busy_o,
    output logic                  deadtrig_o,
    output logic                  trig_done_o,
    output logic                  underflow_o
);

    logic [NSRC-1:0]       w_src_masked;
    logic                  w_req;
    logic                  w_accept;
    logic                  w_dec;
    logic                  w_deadreq;
    logic [PEND_W-1:0]     w_pending_nxt;
    trig_state_t           w_state_nxt;

    logic                  r_active;
    trig_state_t           r_state;
    logic [PEND_W-1:0]     r_pending;
    logic                  r_trig;
    logic [NSRC-1:0]       r_trig_src;
    logic [TRIG_NUM_W-1:0] r_trig_num;
    logic                  r_busy;
    logic                  r_dead;
    logic                  r_done;
    logic                  r_underflow;

    radiant_trigger_scheduler_if #(.HOLD_W(HOLD_W)) w_hold_if ();

    radiant_trig_holdoff #(.HOLD_W(HOLD_W)) u_holdoff (
        .i_clk (sys_clk_i),
        .i_rst (rst_i),
        .hif   (w_hold_if.slave)
    );

    assign w_src_masked = src_i & src_en_i;
    assign w_req        = |w_src_masked;
    assign w_accept     = (r_state == ST_ARMED) && r_active && w_req && !r_busy;
    assign w_dec        = readout_done_i && (r_pending != '0);
    assign w_deadreq    = w_req && r_active && (r_state != ST_DISABLED) && !w_accept;
    assign w_pending_nxt = r_pending + PEND_W'(w_accept) - PEND_W'(w_dec);

    assign w_hold_if.load  = w_accept && (holdoff_i != '0);
    assign w_hold_if.value = holdoff_i;
    assign w_hold_if.clear = !r_active;
    assign w_hold_if.dec   = (r_state == ST_HOLDOFF);

    always_comb begin
        w_state_nxt = r_state;
        if (!r_active) begin
            w_state_nxt = ST_DISABLED;
        end else begin
            case (r_state)
                ST_DISABLED: w_state_nxt = ST_ARMED;
                ST_ARMED:    if (w_accept && (holdoff_i != '0)) w_state_nxt = ST_HOLDOFF;
                ST_HOLDOFF:  if (w_hold_if.expired) w_state_nxt = ST_ARMED;
                default:     w_state_nxt = ST_DISABLED;
            endcase
        end
    end

    // busy is derived from next-cycle pending/state so a full buffer blocks the very next request
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_active    <= 1'b0;
            r_state     <= ST_DISABLED;
            r_pending   <= '0;
            r_trig      <= 1'b0;
            r_trig_src  <= '0;
            r_trig_num  <= '0;
            r_busy      <= 1'b1;
            r_dead      <= 1'b0;
            r_done      <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_active  <= en_i && readout_running_i;
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_trig    <= w_accept;
            if (w_accept) begin
                r_trig_src <= w_src_masked;
                r_trig_num <= r_trig_num + TRIG_NUM_W'(1);
            end
            r_busy <= (w_pending_nxt == PEND_W'(NBUF)) || readout_full_i ||
                      (w_state_nxt != ST_ARMED);
            r_dead <= w_deadreq;
            r_done <= (r_pending != '0) && (w_pending_nxt == '0);
            if (readout_done_i && (r_pending == '0)) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign trig_o      = r_trig;
    assign trig_src_o  = r_trig_src;
    assign trig_num_o  = r_trig_num;
    assign pending_o   = r_pending;
    assign busy_o      = r_busy;
    assign deadtrig_o  = r_dead;
    assign trig_done_o = r_done;
    assign underflow_o = r_underflow;

endmodule

// File: tb/tb_radiant_trigger_scheduler.sv
// Self-checking bench for radiant_trigger_scheduler: vector table plus
// hand-written holdoff, overlap, underflow/reset and counter-wrap sequences.
module tb_radiant_trigger_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  src = '0;
    logic [3:0]  src_en = 4'hF;
    logic        en = 1'b1;
    logic [7:0]  holdoff = '0;
    logic        running = 1'b1;
    logic        done = 1'b0;
    logic        full = 1'b0;

    logic        trig;
    logic [3:0]  trig_src;
    logic [15:0] trig_num;
    logic [3:0]  pending;
    logic        busy;
    logic        dead;
    logic        tdone;
    logic        underflow;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [3:0]  src;
        logic [15:0] num;
    } sb_t;
    sb_t sb[$];
    logic [15:0] exp_num = '0;

    typedef struct {
        logic [3:0] src;
        logic [3:0] en_mask;
        logic       done;
        logic       full;
        logic       trig;
        logic       dead;
        logic       busy;
        logic [3:0] pend;
        logic       tdone;
    } vec_t;
    vec_t vecs[18];

    always #5 clk = ~clk;

    radiant_trigger_scheduler #(.NSRC(4), .NBUF(4), .HOLD_W(8)) dut (
        .sys_clk_i         (clk),
        .rst_i             (rst),
        .src_i             (src),
        .src_en_i          (src_en),
        .en_i              (en),
        .holdoff_i         (holdoff),
        .readout_running_i (running),
        .readout_done_i    (done),
        .readout_full_i    (full),
        .trig_o            (trig),
        .trig_src_o        (trig_src),
        .trig_num_o        (trig_num),
        .pending_o         (pending),
        .busy_o            (busy),
        .deadtrig_o        (dead),
        .trig_done_o       (tdone),
        .underflow_o       (underflow)
    );

    radiant_trigger_scheduler_if #(.HOLD_W(8)) u_hif ();
    radiant_trig_holdoff #(.HOLD_W(8)) u_ho (
        .i_clk (clk),
        .i_rst (rst),
        .hif   (u_hif.slave)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_expect();
        exp_num = exp_num + 16'd1;
        sb.push_back('{src & src_en, exp_num});
    endtask

    function automatic vec_t mk(input logic [3:0] s, input logic [3:0] e, input logic d,
                                input logic f, input logic t, input logic dd, input logic b,
                                input logic [3:0] p, input logic td);
        vec_t v;
        v.src = s; v.en_mask = e; v.done = d; v.full = f;
        v.trig = t; v.dead = dd; v.busy = b; v.pend = p; v.tdone = td;
        return v;
    endfunction

    // Scoreboard: every trig_o pulse must match the next expected accept
    always @(negedge clk) begin
        if (!rst && trig) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_unexpected: trig_o with no expected accept, num=%0h", trig_num);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_trig_src", 32'(trig_src), 32'(e.src));
                chk("sb_trig_num", 32'(trig_num), 32'(e.num));
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_trig"},      32'(trig), 0);
        chk({tag, "_trig_src"},  32'(trig_src), 0);
        chk({tag, "_trig_num"},  32'(trig_num), 0);
        chk({tag, "_pending"},   32'(pending), 0);
        chk({tag, "_busy"},      32'(busy), 1);
        chk({tag, "_dead"},      32'(dead), 0);
        chk({tag, "_tdone"},     32'(tdone), 0);
        chk({tag, "_underflow"}, 32'(underflow), 0);
    endtask

    initial begin
        u_hif.load = 1'b0; u_hif.value = '0; u_hif.clear = 1'b0; u_hif.dec = 1'b0;

        //          src    en     dn    fl    trig  dead  busy  pend  tdone
        vecs[0]  = mk(4'h1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
        vecs[1]  = mk(4'h1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0);
        vecs[2]  = mk(4'h1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 1'b0);
        vecs[3]  = mk(4'h1, 4'hF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd4, 1'b0);
        vecs[4]  = mk(4'h1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
        vecs[5]  = mk(4'h1, 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4, 1'b0);
        vecs[6]  = mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd4, 1'b0);
        vecs[7]  = mk(4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3, 1'b0);
        vecs[8]  = mk(4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0);
        vecs[9]  = mk(4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
        vecs[10] = mk(4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        vecs[11] = mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        vecs[12] = mk(4'h6, 4'h5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 1'b0);
        vecs[13] = mk(4'h2, 4'h5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1, 1'b0);
        vecs[14] = mk(4'h0, 4'h5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
        vecs[15] = mk(4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
        vecs[16] = mk(4'h1, 4'hF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd0, 1'b0);
        vecs[17] = mk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        #1 rst = 1'b1;
        #2 chk_reset_outputs("rst0");
        tick();
        rst = 1'b0;
        tick();
        chk("gate_latency_busy", 32'(busy), 1);
        tick();
        chk("armed_busy", 32'(busy), 0);

        // Buffer fill, drain, source masking and readout_full, from the table
        for (int i = 0; i < 18; i++) begin
            src = vecs[i].src; src_en = vecs[i].en_mask;
            done = vecs[i].done; full = vecs[i].full;
            if (vecs[i].trig) push_expect();
            tick();
            chk($sformatf("v%0d_trig", i),    32'(trig),    32'(vecs[i].trig));
            chk($sformatf("v%0d_dead", i),    32'(dead),    32'(vecs[i].dead));
            chk($sformatf("v%0d_busy", i),    32'(busy),    32'(vecs[i].busy));
            chk($sformatf("v%0d_pending", i), 32'(pending), 32'(vecs[i].pend));
            chk($sformatf("v%0d_tdone", i),   32'(tdone),   32'(vecs[i].tdone));
        end
        src = '0; src_en = 4'hF; done = 1'b0; full = 1'b0;

        // Holdoff 3 with a request every cycle: accept every 4th cycle
        holdoff = 8'd3;
        for (int i = 0; i < 12; i++) begin
            src = 4'h1;
            if (i % 4 == 0) push_expect();
            tick();
            chk($sformatf("ho%0d_trig", i), 32'(trig), (i % 4 == 0) ? 1 : 0);
            chk($sformatf("ho%0d_dead", i), 32'(dead), (i % 4 == 0) ? 0 : 1);
            chk($sformatf("ho%0d_num", i),  32'(trig_num), 32'(exp_num));
        end
        src = '0; holdoff = '0;
        done = 1'b1;
        repeat (3) tick();
        done = 1'b0;
        tick();
        chk("ho_drain_pending", 32'(pending), 0);

        // Accept and readout_done in the same cycle
        src = 4'h1; push_expect();
        tick();
        done = 1'b1; push_expect();
        tick();
        chk("ovl_trig", 32'(trig), 1);
        chk("ovl_pending", 32'(pending), 1);
        chk("ovl_tdone", 32'(tdone), 0);
        src = '0;
        tick();
        chk("ovl_drain_pending", 32'(pending), 0);
        chk("ovl_drain_tdone", 32'(tdone), 1);
        done = 1'b0;
        tick();
        chk("ovl_tdone_single", 32'(tdone), 0);

        // Underflow is sticky; reset mid-holdoff clears everything at once
        done = 1'b1;
        tick();
        chk("uf_set", 32'(underflow), 1);
        chk("uf_pending", 32'(pending), 0);
        done = 1'b0;
        tick(); tick();
        chk("uf_sticky", 32'(underflow), 1);
        holdoff = 8'd5; src = 4'h1; push_expect();
        tick();
        src = '0;
        tick();
        chk("ho_mid_busy", 32'(busy), 1);
        chk("ho_mid_pending", 32'(pending), 1);
        #2 rst = 1'b1;
        #1 chk_reset_outputs("rst_async");
        exp_num = '0;
        tick();
        chk("rst_hold_tdone", 32'(tdone), 0);
        chk("rst_hold_busy", 32'(busy), 1);

        // Requests while disabled are silently ignored
        en = 1'b0; holdoff = '0;
        rst = 1'b0;
        src = 4'h1;
        repeat (3) begin
            tick();
            chk("dis_trig", 32'(trig), 0);
            chk("dis_dead", 32'(dead), 0);
        end
        src = '0; en = 1'b1;
        tick(); tick();
        chk("rearm_busy", 32'(busy), 0);
        chk("rearm_tdone", 32'(tdone), 0);

        // trig_num wrap: 65535 accepts then one more
        src = 4'h1; push_expect();
        tick();
        done = 1'b1;
        for (int i = 0; i < 65534; i++) begin
            push_expect();
            tick();
        end
        chk("wrap_pre_num", 32'(trig_num), 32'hFFFF);
        chk("wrap_pre_pending", 32'(pending), 1);
        push_expect();
        tick();
        chk("wrap_trig", 32'(trig), 1);
        chk("wrap_num", 32'(trig_num), 0);
        chk("wrap_pending", 32'(pending), 1);
        src = '0;
        tick();
        chk("wrap_drain_tdone", 32'(tdone), 1);
        done = 1'b0;
        tick();

        // Standalone holdoff counter
        u_hif.load = 1'b1; u_hif.value = 8'd2;
        tick();
        u_hif.load = 1'b0;
        chk("hc_load2_expired", 32'(u_hif.expired), 0);
        u_hif.dec = 1'b1;
        tick();
        chk("hc_dec_expired", 32'(u_hif.expired), 1);
        u_hif.dec = 1'b0; u_hif.load = 1'b1; u_hif.value = 8'd4;
        tick();
        u_hif.load = 1'b0;
        chk("hc_load4_expired", 32'(u_hif.expired), 0);
        u_hif.clear = 1'b1;
        tick();
        u_hif.clear = 1'b0;
        chk("hc_clear_expired", 32'(u_hif.expired), 1);

        tick();
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/radiant_trigger_scheduler.md
RADIANT_TRIGGER_SCHEDULER -- requirements
Module: radiant_trigger_scheduler

Interface
REQ-001 The block SHALL have parameter NSRC, default 4, giving the number of trigger sources (1..16).
REQ-002 The block SHALL have parameter NBUF, default 4, giving the maximum outstanding events (1..15).
REQ-003 The block SHALL have parameter HOLD_W, default 8, giving the holdoff counter width.
REQ-004 The block SHALL have port sys_clk_i, input, 1 bit: the single clock for all logic.
REQ-005 The block SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port src_i, input, NSRC bits: sys_clk trigger request pulses.
REQ-007 The block SHALL have port src_en_i, input, NSRC bits: per-source enables.
REQ-008 The block SHALL have port en_i, input, 1 bit: global enable.
REQ-009 The block SHALL have port holdoff_i, input, HOLD_W bits: dead cycles after each accepted trigger.
REQ-010 The block SHALL have port readout_running_i, input, 1 bit: LAB4 controller running.
REQ-011 The block SHALL have port readout_done_i, input, 1 bit: pulse, one event fully read out.
REQ-012 The block SHALL have port readout_full_i, input, 1 bit: LAB4 FIFO full.
REQ-013 The block SHALL have port trig_o, output, 1 bit: one-cycle accepted-trigger pulse.
REQ-014 The block SHALL have port trig_src_o, output, NSRC bits: source mask for the last accepted trigger.
REQ-015 The block SHALL have port trig_num_o, output, 16 bits: count of accepted triggers.
REQ-016 The block SHALL have port pending_o, output, 4 bits: number of outstanding events.
REQ-017 The block SHALL have port busy_o, output, 1 bit: new triggers are refused.
REQ-018 The block SHALL have port deadtrig_o, output, 1 bit: one-cycle pulse on a refused enabled request.
REQ-019 The block SHALL have port trig_done_o, output, 1 bit: one-cycle pulse when pending returns to 0.
REQ-020 The block SHALL have port underflow_o, output, 1 bit: sticky, set by readout_done_i with pending 0.

Function
REQ-021 The block SHALL compute req = |(src_i & src_en_i) combinationally each cycle.
REQ-022 The block SHALL register the gate signal active = en_i && readout_running_i, so that disabling takes effect 1 cycle later.
REQ-023 The block SHALL implement a state machine with states DISABLED, ARMED and HOLDOFF.
REQ-024 From DISABLED, the state machine SHALL move to ARMED when active=1.
REQ-025 From any state, the state machine SHALL move to DISABLED when active=0. The hold counter SHALL be cleared; pending SHALL NOT be cleared.
REQ-026 In ARMED, when req=1 and busy_o=0, the block SHALL assert trig_o in the next cycle (1-cycle latency from src_i).
REQ-027 On that accept, trig_src_o SHALL load src_i & src_en_i, and trig_num_o SHALL increment, wrapping from 0xFFFF to 0.
REQ-028 On that accept, pending SHALL increment.
REQ-029 On that accept, the state SHALL go to HOLDOFF if holdoff_i != 0, with the hold counter loaded with holdoff_i; otherwise it SHALL stay in ARMED, allowing back-to-back accepts.
REQ-030 In HOLDOFF, the counter SHALL decrement each cycle and the state SHALL return to ARMED in the cycle the counter reaches 1, giving exactly holdoff_i refused cycles.
REQ-031 busy_o SHALL equal (pending == NBUF) || readout_full_i || state != ARMED, and SHALL be registered.
REQ-032 deadtrig_o SHALL pulse for an enabled req refused while active=1; requests during DISABLED SHALL produce no pulse.
REQ-033 readout_done_i SHALL decrement pending when pending > 0, in any state.
REQ-034 A simultaneous accept and readout_done_i SHALL leave pending unchanged.
REQ-035 A readout_done_i with pending 0 SHALL leave pending at 0 and SHALL set underflow_o, which is cleared only by rst_i.
REQ-036 trig_done_o SHALL pulse in the cycle after pending transitions from nonzero to 0.

Reset
REQ-037 While rst_i=1, asynchronously: state SHALL be DISABLED; pending, trig_num_o, trig_src_o and the hold counter SHALL be 0; trig_o, deadtrig_o, trig_done_o and underflow_o SHALL be 0; busy_o SHALL be 1.
REQ-038 A reset asserted mid-holdoff or with events pending SHALL discard all state with no trig_done_o pulse.

Structure
REQ-039 A shared package radiant_trig_pkg SHALL hold the state enum typedef, the trig_num width constant (16) and the pending width constant (4).
REQ-040 The holdoff down-counter SHALL be one sub-module, radiant_trig_holdoff, with load, value and expired signals.
REQ-041 The block SHALL contain no SRL primitives and no IOB attributes.

Verification
REQ-042 Bench case 1: with NBUF=4 and holdoff 0, send 6 consecutive src_i[0] pulses -> 4 trig_o pulses, pending=4, busy_o=1, and 2 deadtrig_o pulses.
REQ-043 Bench case 2: with holdoff_i=3, send src_i pulses every cycle -> trig_o every 4th cycle and trig_num_o increments by 1 each time.
REQ-044 Bench case 3: with pending=1, assert a trigger and readout_done_i in the same cycle -> pending stays 1 and there is no trig_done_o pulse.
REQ-045 Bench case 4: with src_en_i=0b0101, pulse src_i=0b0110 -> trig_src_o=0b0100; then pulse src_i=0b0010 -> no trig_o and no deadtrig_o.
REQ-046 Bench case 5: pulse readout_done_i with pending 0 -> underflow_o=1 sticky and pending=0; rst_i during HOLDOFF -> all outputs return to their reset values immediately.
REQ-047 Bench case 6: preload trig_num_o to 0xFFFF via 65535 accepts -> the next accept gives trig_num_o=0x0000.
